// File: rtl/buzzer_soc_pkg.sv
// buzzer_soc_pkg: shared master IDs and default lock-burst length for the Block_RAM arbiter
package buzzer_soc_pkg;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;
  localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational two-master pick; lock forces M1, otherwise prefer_m0 breaks contention
module ram_arb_pick (
  input  logic m0_req,
  input  logic m1_req,
  input  logic lock,
  input  logic prefer_m0,
  output logic m0_gnt,
  output logic m1_gnt
);
  assign m1_gnt = m1_req & (lock | ~m0_req | ~prefer_m0);
  assign m0_gnt = m0_req & ~m1_gnt;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: CPU/DMA arbiter for one Block_RAM with bounded M1 lock bursts; define RAM_ARB_RR_EN for round-robin contention
module ram_port_arbiter
  import buzzer_soc_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic [3:0]            m0_we,
  input  logic [3:0]            m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [31:0]           m1_wdata,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [31:0]           m0_rdata,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  input  logic [31:0]           ram_doutb
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic burst_q, burst_d, m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] dina_q, dina_d;
  logic lock_want, lock, prefer_m0, pick0, pick1;
`ifdef RAM_ARB_RR_EN
  master_e last_gnt_q, last_gnt_d;
  always_comb last_gnt_d = m0_gnt ? M0 : m1_gnt ? M1 : last_gnt_q;
  always_ff @(posedge clka) last_gnt_q <= rst ? M1 : last_gnt_d;
  assign prefer_m0 = last_gnt_q == M1;
`else
  assign prefer_m0 = 1'b1;
`endif
  assign lock_want = burst_q & m1_lock & m1_req;
  assign lock = lock_want & (hold_cnt_q < HW'(MAX_HOLD));
  ram_arb_pick u_pick (
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .lock     (lock),
    .prefer_m0(prefer_m0),
    .m0_gnt   (pick0),
    .m1_gnt   (pick1)
  );
  assign m0_gnt = pick0 & ~rst;
  assign m1_gnt = pick1 & ~rst;
  always_comb begin
    hold_cnt_d  = ~m1_gnt ? '0 : hold_cnt_q == HW'(MAX_HOLD) ? hold_cnt_q : hold_cnt_q + HW'(1);
    burst_d     = m1_gnt ? m1_lock : m0_gnt & lock_want;
    m0_rvalid_d = m0_gnt & ~|m0_we;
    m1_rvalid_d = m1_gnt & ~|m1_we;
    addr_d      = m0_gnt ? m0_addr : m1_gnt ? m1_addr : addr_q;
    dina_d      = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : dina_q;
  end
  always_ff @(posedge clka) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      burst_q     <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      addr_q      <= '0;
      dina_q      <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      burst_q     <= burst_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      addr_q      <= addr_d;
      dina_q      <= dina_d;
    end
  end
  assign ram_addra = addr_d;
  assign ram_addrb = addr_d;
  assign ram_dina  = dina_d;
  assign ram_wea   = m0_gnt ? m0_we : m1_gnt ? m1_we : 4'b0000;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_doutb;
  assign m1_rdata  = ram_doutb;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors and multi-cycle sequences for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int AW = 14;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clka = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [3:0] m0_we = '0, m1_we = '0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, ram_dina, ram_doutb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0] ram_wea;
  logic [31:0] mem [0:(1<<AW)-1];
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic r0, r1;
    logic [3:0] w0, w1;
    logic [AW-1:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0] exp_gnt;
    logic [3:0] exp_wea;
    logic [AW-1:0] exp_addr;
    logic [1:0] exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t v [9];
  always #5 clka = ~clka;
  ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(8)) dut (
    .clka(clka), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_doutb(ram_doutb)
  );
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    ram_doutb <= mem[ram_addrb];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic r0, input logic r1, input logic lk,
                       input logic [3:0] w0, input logic [3:0] w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clka);
    #1;
    rst = r; m0_req = r0; m1_req = r1; m1_lock = lk;
    m0_we = w0; m1_we = w1; m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1;
    @(negedge clka);
  endtask
  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0);
  endtask
  initial begin
    int m1_cnt, m0_cnt;
    logic [12:0] lock_pat;
    mem[14'h10] = 32'hDEADBEEF;
    mem[14'h20] = 32'hAABBCCDD;
    mem[14'h30] = 32'h11112222;
    v[0] = '{1'b0, 1'b0, 4'h0, 4'h0, 14'h00, 14'h00, 32'h0, 32'h0, 2'b00, 4'h0, 14'h00, 2'b00, 32'h0};
    v[1] = '{1'b1, 1'b0, 4'h0, 4'h0, 14'h10, 14'h00, 32'h0, 32'h0, 2'b01, 4'h0, 14'h10, 2'b00, 32'h0};
    v[2] = '{1'b0, 1'b0, 4'h0, 4'h0, 14'h00, 14'h00, 32'h0, 32'h0, 2'b00, 4'h0, 14'h10, 2'b01, 32'hDEADBEEF};
    v[3] = '{1'b0, 1'b1, 4'h0, 4'h0, 14'h00, 14'h30, 32'h0, 32'h0, 2'b10, 4'h0, 14'h30, 2'b00, 32'h0};
    v[4] = '{1'b1, 1'b0, 4'h3, 4'h0, 14'h20, 14'h00, 32'h12345678, 32'h0, 2'b01, 4'h3, 14'h20, 2'b10, 32'h11112222};
    v[5] = '{1'b1, 1'b0, 4'h0, 4'h0, 14'h20, 14'h00, 32'h0, 32'h0, 2'b01, 4'h0, 14'h20, 2'b00, 32'h0};
    v[6] = '{1'b0, 1'b1, 4'h0, 4'hF, 14'h55, 14'h30, 32'h0, 32'hCAFEF00D, 2'b10, 4'hF, 14'h30, 2'b01, 32'hAABB5678};
    v[7] = '{1'b0, 1'b1, 4'h0, 4'h0, 14'h00, 14'h30, 32'h0, 32'h0, 2'b10, 4'h0, 14'h30, 2'b00, 32'h0};
    v[8] = '{1'b0, 1'b0, 4'hF, 4'hF, 14'h77, 14'h66, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 4'h0, 14'h30, 2'b10, 32'hCAFEF00D};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h10, 14'h00, 32'h0, 32'h0);
    chk("rst_gnt_read", {m1_gnt, m0_gnt}, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 14'h20, 14'h30, 32'h1, 32'h2);
    chk("rst_gnt_write", {m1_gnt, m0_gnt}, 2'b00);
    chk("rst_wea", ram_wea, 4'h0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, v[i].r0, v[i].r1, 1'b0, v[i].w0, v[i].w1, v[i].a0, v[i].a1, v[i].d0, v[i].d1);
      chk($sformatf("v%0d_gnt", i), {m1_gnt, m0_gnt}, v[i].exp_gnt);
      chk($sformatf("v%0d_wea", i), ram_wea, v[i].exp_wea);
      chk($sformatf("v%0d_addra", i), ram_addra, v[i].exp_addr);
      chk($sformatf("v%0d_addrb", i), ram_addrb, v[i].exp_addr);
      chk($sformatf("v%0d_rvalid", i), {m1_rvalid, m0_rvalid}, v[i].exp_rv);
      if (v[i].exp_wea != 4'h0) chk($sformatf("v%0d_dina", i), ram_dina, v[i].exp_gnt[0] ? v[i].d0 : v[i].d1);
      if (v[i].exp_rv[0]) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, v[i].exp_rdata);
      if (v[i].exp_rv[1]) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, v[i].exp_rdata);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 14'h10, 14'h30, '0, '0);
      chk($sformatf("contend%0d_gnt", i), {m1_gnt, m0_gnt}, (RR && i % 2 == 1) ? 2'b10 : 2'b01);
    end
    do_reset();
    lock_pat = 13'b1111_0_1111_1111;
    m1_cnt = 0;
    m0_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, i > 0, 1'b1, 1'b1, 4'h0, 4'h0, 14'h10, 14'h30, '0, '0);
      chk($sformatf("lock%0d_gnt", i), {m1_gnt, m0_gnt}, lock_pat[i] ? 2'b10 : 2'b01);
      m1_cnt += int'(m1_gnt);
      m0_cnt += int'(m0_gnt);
    end
    chk("lock_m1_total", m1_cnt, 12);
    chk("lock_m0_total", m0_cnt, 1);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, '0, 14'h30, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, '0, 14'h30, '0, '0);
    chk("rst_lock_gnt", {m1_gnt, m0_gnt}, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 14'h10, 14'h30, '0, '0);
    chk("post_rst_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("post_rst_m1_rvalid", m1_rvalid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0);
    chk("post_rst_m0_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("post_rst_m0_rdata", m0_rdata, 32'hDEADBEEF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, giving the word-address width of the shared Block_RAM.
REQ-002 SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive locked grants to M1.
REQ-003 SHALL have port clka, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports m0_req/m1_req, input, 1 bit each: access request from master 0 (CPU) and master 1 (player DMA).
REQ-006 SHALL have ports m0_we/m1_we, input, 4 bits each: byte write enables; all-zero means a read.
REQ-007 SHALL have ports m0_addr/m1_addr, input, ADDR_WIDTH bits each: word address.
REQ-008 SHALL have ports m0_wdata/m1_wdata, input, 32 bits each: write data.
REQ-009 SHALL have port m1_lock, input, 1 bit: M1 requests an uninterrupted burst.
REQ-010 SHALL have ports m0_gnt/m1_gnt, output, 1 bit each: access accepted this cycle.
REQ-011 SHALL have ports m0_rvalid/m1_rvalid, output, 1 bit each: read data valid.
REQ-012 SHALL have ports m0_rdata/m1_rdata, output, 32 bits each: read data.
REQ-013 SHALL have ports ram_addra and ram_addrb, output, ADDR_WIDTH bits each: RAM write address and read address.
REQ-014 SHALL have port ram_dina, output, 32 bits: RAM write data.
REQ-015 SHALL have port ram_wea, output, 4 bits: RAM byte write enables.
REQ-016 SHALL have port ram_doutb, input, 32 bits: RAM registered read data, valid one cycle after ram_addrb.

Function
REQ-017 SHALL grant at most one master per cycle; m0_gnt and m1_gnt are never both 1.
REQ-018 SHALL make grants combinational on the current-cycle req and the registered arbitration state, so a request is accepted in the cycle it is presented.
REQ-019 SHALL route the granted master to the RAM: ram_addra=ram_addrb=addr, ram_dina=wdata, ram_wea=we; ram_wea SHALL be 4'b0000 when no master is granted.
REQ-020 SHALL hold ram_addr*/ram_dina at the last driven value when idle.
REQ-021 SHALL, for a granted read, assert that master's rvalid exactly one cycle later for one cycle, with rdata=ram_doutb in that cycle.
REQ-022 SHALL keep rvalid low after writes; rdata SHALL be don't-care when rvalid=0.
REQ-023 SHALL return the new value for a read issued in the cycle after a write to the same address.
REQ-024 SHALL handle lock: if M1 was granted last cycle and m1_lock=1 and m1_req=1, M1 is granted regardless of m0_req while hold_cnt<MAX_HOLD.
REQ-025 SHALL increment hold_cnt (saturating at MAX_HOLD) on each consecutive M1 grant and clear it on any non-M1 cycle.
REQ-026 SHALL, at hold_cnt==MAX_HOLD with m0_req=1, grant M0 for one cycle; lock SHALL then resume.
REQ-027 SHALL, with a single requester, grant it every cycle.
REQ-028 SHALL track last_gnt (registered) and use it only for the round-robin mode.

Reset
REQ-029 SHALL, on rst=1, clear gnts, rvalids, ram_wea, hold_cnt, and set last_gnt=M1.
REQ-030 SHALL drop a read granted in the cycle of reset: no rvalid follows.
REQ-031 SHALL let reset override lock.

Configuration
REQ-032 SHALL, with macro RAM_ARB_RR_EN defined, arbitrate non-locked contention round-robin, granting the master not equal to last_gnt.
REQ-033 SHALL, without RAM_ARB_RR_EN, arbitrate non-locked contention by fixed priority, M0 winning.

Structure
REQ-034 SHALL place master-ID encoding (M0=0, M1=1) and the default MAX_HOLD in shared package buzzer_soc_pkg.
REQ-035 SHALL use one natural sub-module, ram_arb_pick, holding the combinational priority/round-robin pick.

Verification
REQ-036 SHALL verify: M0 reads addr 0x10 holding 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle with m0_rdata=0xDEADBEEF.
REQ-037 SHALL verify: both request, no lock -> fixed mode M0 granted every cycle; RR mode gnt alternates M0,M1,M0,M1 starting M0 after reset.
REQ-038 SHALL verify: M1 locked burst of 12 with M0 requesting, MAX_HOLD=8 -> 8 M1 grants, 1 M0 grant, 4 M1 grants.
REQ-039 SHALL verify: M0 writes 0x12345678 to 0x20 with we=4'b0011, then reads 0x20 next cycle -> rdata low half 0x5678, upper half unchanged.
REQ-040 SHALL verify: rst asserted in the cycle of an M1 read grant -> no m1_rvalid, hold_cnt=0, next contention in RR mode grants M0.
